// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO and configurable frame format.
// Frames stream back-to-back while words are queued; all outputs are registered.
module uart_tx_fifo #(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    localparam int BIT_CYCLES = CLOCK_RATE / BAUD_RATE;
    localparam int BAUD_W     = $clog2(BIT_CYCLES);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == 2) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]     count_r, count_s;
    logic                 full_r, empty_r, overflow_r;
    state_t               state_r, state_s;
    logic [BAUD_W-1:0]    baud_r, baud_s, baud_inc_s;
    logic [2:0]           bit_r, bit_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 par_r, par_s;
    logic                 tx_r, tx_s, busy_r, busy_s, done_r, done_s;
    logic                 push_s, pop_s, bit_end_s;

    assign full     = full_r;
    assign empty    = empty_r;
    assign overflow = overflow_r;
    assign tx       = tx_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Frame sequencer: next state, counters and the registered-output values for the next cycle.
    always_comb begin
        state_s    = state_r;
        baud_s     = baud_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        par_s      = par_r;
        pop_s      = 1'b0;
        bit_end_s  = (baud_r == BAUD_LAST);
        baud_inc_s = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        case (state_r)
            S_IDLE: begin
                baud_s = '0;
                bit_s  = 3'd0;
                if (!empty_r) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rd_ptr_r];
                    par_s   = parity_bit(mem_r[rd_ptr_r]);
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    baud_s  = '0;
                    bit_s   = 3'd0;
                    state_s = S_DATA;
                end else begin
                    baud_s = baud_inc_s;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_s  = '0;
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_r == DATA_LAST) begin
                        bit_s   = 3'd0;
                        state_s = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_inc_s;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    baud_s  = '0;
                    bit_s   = 3'd0;
                    state_s = S_STOP;
                end else begin
                    baud_s = baud_inc_s;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    baud_s = '0;
                    if (bit_r == STOP_LAST) begin
                        bit_s = 3'd0;
                        // Pop in the final stop cycle so the next start bit follows with no gap.
                        if (!empty_r) begin
                            pop_s   = 1'b1;
                            shift_s = mem_r[rd_ptr_r];
                            par_s   = parity_bit(mem_r[rd_ptr_r]);
                            state_s = S_START;
                        end else begin
                            state_s = S_IDLE;
                        end
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_inc_s;
                end
            end
            default: begin
                state_s = S_IDLE;
                baud_s  = '0;
                bit_s   = 3'd0;
            end
        endcase

        case (state_s)
            S_START:  tx_s = 1'b0;
            S_DATA:   tx_s = shift_s[0];
            S_PARITY: tx_s = par_s;
            default:  tx_s = 1'b1;
        endcase
        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_STOP) && (baud_s == BAUD_LAST) && (bit_s == STOP_LAST);
    end

    // FIFO occupancy: accept only when not full before the edge.
    always_comb begin
        push_s = wr_en && !full_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            state_r    <= S_IDLE;
            baud_r     <= '0;
            bit_r      <= 3'd0;
            shift_r    <= '0;
            par_r      <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r    <= count_s;
            full_r     <= (count_s == DEPTH_CNT);
            empty_r    <= (count_s == '0);
            overflow_r <= wr_en && full_r;
            state_r    <= state_s;
            baud_r     <= baud_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            par_r      <= par_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

endmodule
